// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control path: opcodes, function codes, ALU
// control codes, controller state and instruction class.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_ORI = 3'b010;
    localparam logic [2:0] ALU_LW  = 3'b110;
    localparam logic [2:0] ALU_SW  = 3'b111;
    localparam logic [2:0] ALU_BEQ = 3'b101;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsNone = 3'd0,
        ClsAdd  = 3'd1,
        ClsSub  = 3'd2,
        ClsOri  = 3'd3,
        ClsLw   = 3'd4,
        ClsSw   = 3'd5,
        ClsBeq  = 3'd6
    } insn_class_e;

    // ALU operation associated with an instruction class once it has been decoded.
    function automatic logic [2:0] alu_code(insn_class_e cls);
        logic [2:0] code;
        case (cls)
            ClsSub:  code = ALU_SUB;
            ClsOri:  code = ALU_ORI;
            ClsLw:   code = ALU_LW;
            ClsSw:   code = ALU_SW;
            ClsBeq:  code = ALU_BEQ;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction classifier: op/funct -> instruction class, with
// an illegal flag for any encoding outside the supported set.
module insn_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output insn_class_e cls,
    output logic        illegal
);

    // Map the opcode (and funct for R-type) onto a class; unknown -> illegal.
    always_comb begin
        cls     = ClsNone;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADD) begin
                    cls = ClsAdd;
                end else if (funct == FN_SUB) begin
                    cls = ClsSub;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ORI:  cls = ClsOri;
            OP_LW:   cls = ClsLw;
            OP_SW:   cls = ClsSw;
            OP_BEQ:  cls = ClsBeq;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the simple CPU datapath. Sequences IF/ID/EX/MEM/WB,
// decodes datapath strobes from state and latched class, and aborts a stalled
// memory access with a watchdog.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CW          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       carrier,
    input  logic       mem_ready,
    output logic [2:0] ALUctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       bus_err,
    output logic       carry_flag,
    output logic [2:0] state
);

    state_e      state_q, state_d;
    insn_class_e cls_q, cls_d;
    logic [CW-1:0] wait_q, wait_d;
    logic        carry_q, carry_d;

    insn_class_e dec_cls;
    logic        dec_illegal;
    logic        waiting;
    logic        timeout;

    insn_decode u_decode (
        .op      (op),
        .funct   (funct),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    // Watchdog: a memory access that has stalled MEM_TIMEOUT cycles is abandoned,
    // unless mem_ready arrives in that final cycle.
    always_comb begin
        waiting = ((state_q == StIf) || (state_q == StMem)) && !mem_ready;
        timeout = waiting && (wait_q == CW'(MEM_TIMEOUT - 1));
    end

    // Next state, class latch, carry capture and wait counter.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        carry_d = carry_q;
        case (state_q)
            StIf: begin
                if (mem_ready) begin
                    state_d = StId;
                end
            end
            StId: begin
                cls_d   = dec_cls;
                state_d = dec_illegal ? StIf : StEx;
            end
            StEx: begin
                case (cls_q)
                    ClsAdd, ClsSub: begin
                        state_d = StWb;
                        carry_d = carrier;
                    end
                    ClsOri:        state_d = StWb;
                    ClsLw, ClsSw:  state_d = StMem;
                    default:       state_d = StIf;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsLw) ? StWb : StIf;
                end else if (timeout) begin
                    state_d = StIf;
                end
            end
            default: state_d = StIf;
        endcase

        // Counter restarts on any state change and after an abort that stays in IF.
        if ((state_d != state_q) || timeout) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Controller state register with asynchronous reset into IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIf;
            cls_q   <= ClsNone;
            wait_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            carry_q <= carry_d;
        end
    end

    // Datapath strobes decoded from state and latched class.
    always_comb begin
        ALUctrl    = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        pc_src     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            StIf: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                bus_err   = timeout;
            end
            StId: begin
                // Branch target PC + (imm << 2) is computed speculatively here.
                alu_src_b = 2'b11;
                illegal   = dec_illegal;
            end
            StEx: begin
                ALUctrl   = alu_code(cls_q);
                alu_src_a = 1'b1;
                case (cls_q)
                    ClsOri: alu_src_b = 2'b10;
                    ClsLw, ClsSw: begin
                        alu_src_b = 2'b10;
                        ext_op    = 1'b1;
                    end
                    ClsBeq: begin
                        pc_src   = 1'b1;
                        pc_write = zero;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                ALUctrl   = alu_code(cls_q);
                mem_read  = (cls_q == ClsLw);
                mem_write = (cls_q == ClsSw);
                bus_err   = timeout;
            end
            StWb: begin
                ALUctrl    = alu_code(cls_q);
                reg_write  = 1'b1;
                reg_dst    = (cls_q == ClsAdd) || (cls_q == ClsSub);
                mem_to_reg = (cls_q == ClsLw);
            end
            default: ;
        endcase
    end

    assign carry_flag = carry_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each cycle's stimulus is queued with the
// full expected output vector, then replayed and compared mid-cycle.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       carrier = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] ALUctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op, pc_src, pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, illegal, bus_err, carry_flag;
    logic [2:0] state;

    multicycle_ctrl #(
        .MEM_TIMEOUT (15),
        .CW          (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .carrier    (carrier),
        .mem_ready  (mem_ready),
        .ALUctrl    (ALUctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .carry_flag (carry_flag),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] aluctrl;
        logic       src_a;
        logic [1:0] src_b;
        logic       ext;
        logic       pcsrc;
        logic       pcw;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       ill;
        logic       berr;
        logic       carry;
        logic [2:0] st;
    } outs_t;

    typedef struct {
        string      tag;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       carrier;
        logic       ready;
        outs_t      exp;
    } entry_t;

    entry_t sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    logic   exp_carry = 1'b0;
    outs_t  obs;
    outs_t  e;

    assign obs = {ALUctrl, alu_src_a, alu_src_b, ext_op, pc_src, pc_write, ir_write, mem_read,
                  mem_write, reg_write, reg_dst, mem_to_reg, illegal, bus_err, carry_flag, state};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic outs_t o_st(logic [2:0] st, logic [2:0] alu);
        outs_t o = '0;
        o.st      = st;
        o.aluctrl = alu;
        o.carry   = exp_carry;
        return o;
    endfunction

    function automatic outs_t o_if(logic rdy);
        outs_t o = o_st(3'd0, ALU_ADD);
        o.src_b = 2'b01;
        o.mrd   = 1'b1;
        o.irw   = rdy;
        o.pcw   = rdy;
        return o;
    endfunction

    function automatic outs_t o_id(logic ill);
        outs_t o = o_st(3'd1, ALU_ADD);
        o.src_b = 2'b11;
        o.ill   = ill;
        return o;
    endfunction

    task automatic push(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic c, input logic r, input outs_t ex);
        entry_t t;
        t.tag = tag; t.op = o; t.funct = f; t.zero = z; t.carrier = c; t.ready = r; t.exp = ex;
        sb.push_back(t);
    endtask

    // IF with `waits` stall cycles, then ID (legal unless `ill`).
    task automatic fetch_decode(input string nm, input int waits, input logic [5:0] o,
                                input logic [5:0] f, input logic ill);
        for (int i = 0; i < waits; i++) push({nm, "_ifw"}, o, f, 1'b0, 1'b0, 1'b0, o_if(1'b0));
        push({nm, "_if"}, o, f, 1'b0, 1'b0, 1'b1, o_if(1'b1));
        push({nm, "_id"}, o, f, 1'b0, 1'b0, 1'b0, o_id(ill));
    endtask

    task automatic run_sb();
        entry_t t;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            @(negedge clk);
            op = t.op; funct = t.funct; zero = t.zero; carrier = t.carrier; mem_ready = t.ready;
            #1;
            check(t.tag, 32'(obs), 32'(t.exp));
        end
    endtask

    initial begin
        // Reset values visible without any clock edge.
        #2;
        check("reset", 32'(obs), 32'(o_if(1'b0)));
        #5 rst_n = 1'b1;

        // ADD, carrier=1 in EX.
        fetch_decode("add", 0, OP_RTYPE, FN_ADD, 1'b0);
        e = o_st(3'd2, ALU_ADD); e.src_a = 1'b1;
        push("add_ex", OP_RTYPE, FN_ADD, 1'b0, 1'b1, 1'b0, e);
        exp_carry = 1'b1;
        e = o_st(3'd4, ALU_ADD); e.rw = 1'b1; e.rdst = 1'b1;
        push("add_wb", OP_RTYPE, FN_ADD, 1'b0, 1'b0, 1'b0, e);

        // SUB, carrier=0 in EX clears carry_flag.
        fetch_decode("sub", 1, OP_RTYPE, FN_SUB, 1'b0);
        e = o_st(3'd2, ALU_SUB); e.src_a = 1'b1;
        push("sub_ex", OP_RTYPE, FN_SUB, 1'b1, 1'b0, 1'b1, e);
        exp_carry = 1'b0;
        e = o_st(3'd4, ALU_SUB); e.rw = 1'b1; e.rdst = 1'b1;
        push("sub_wb", OP_RTYPE, FN_SUB, 1'b0, 1'b1, 1'b0, e);

        // ORI with carrier=1 in EX: carry_flag must hold.
        fetch_decode("ori", 0, OP_ORI, 6'h15, 1'b0);
        e = o_st(3'd2, ALU_ORI); e.src_a = 1'b1; e.src_b = 2'b10;
        push("ori_ex", OP_ORI, 6'h15, 1'b0, 1'b1, 1'b0, e);
        e = o_st(3'd4, ALU_ORI); e.rw = 1'b1;
        push("ori_wb", OP_ORI, 6'h15, 1'b0, 1'b1, 1'b0, e);
        run_sb();

        // LW with 3 MEM wait states.
        fetch_decode("lw", 2, OP_LW, 6'h00, 1'b0);
        e = o_st(3'd2, ALU_LW); e.src_a = 1'b1; e.src_b = 2'b10; e.ext = 1'b1;
        push("lw_ex", OP_LW, 6'h00, 1'b0, 1'b0, 1'b1, e);
        e = o_st(3'd3, ALU_LW); e.mrd = 1'b1;
        for (int i = 0; i < 3; i++) push("lw_memw", OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, e);
        push("lw_mem", OP_LW, 6'h00, 1'b0, 1'b0, 1'b1, e);
        e = o_st(3'd4, ALU_LW); e.rw = 1'b1; e.m2r = 1'b1;
        push("lw_wb", OP_LW, 6'h00, 1'b0, 1'b0, 1'b1, e);

        // SW, no waits.
        fetch_decode("sw", 0, OP_SW, 6'h00, 1'b0);
        e = o_st(3'd2, ALU_SW); e.src_a = 1'b1; e.src_b = 2'b10; e.ext = 1'b1;
        push("sw_ex", OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e);
        e = o_st(3'd3, ALU_SW); e.mwr = 1'b1;
        push("sw_mem", OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, e);

        // BEQ taken, then not taken.
        for (int z = 1; z >= 0; z--) begin
            fetch_decode("beq", 0, OP_BEQ, 6'h00, 1'b0);
            e = o_st(3'd2, ALU_BEQ); e.src_a = 1'b1; e.pcsrc = 1'b1; e.pcw = 1'(z);
            push(z != 0 ? "beq_t_ex" : "beq_nt_ex", OP_BEQ, 6'h00, 1'(z), 1'b0, 1'b1, e);
        end

        // Illegal opcode and illegal R-type funct.
        fetch_decode("ill_op", 0, 6'b111111, 6'h00, 1'b1);
        fetch_decode("ill_fn", 0, OP_RTYPE, 6'b000000, 1'b1);
        run_sb();

        // IF watchdog: abort on 15th stalled cycle, then ready on 15th cycle wins.
        for (int i = 0; i < 14; i++) push("to_ifw", OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0, o_if(1'b0));
        e = o_if(1'b0); e.berr = 1'b1;
        push("to_if_abort", OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0, e);
        fetch_decode("to_late", 14, OP_ORI, 6'h00, 1'b0);
        e = o_st(3'd2, ALU_ORI); e.src_a = 1'b1; e.src_b = 2'b10;
        push("to_ori_ex", OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0, e);
        e = o_st(3'd4, ALU_ORI); e.rw = 1'b1;
        push("to_ori_wb", OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0, e);

        // MEM watchdog on a store.
        fetch_decode("swto", 0, OP_SW, 6'h00, 1'b0);
        e = o_st(3'd2, ALU_SW); e.src_a = 1'b1; e.src_b = 2'b10; e.ext = 1'b1;
        push("swto_ex", OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e);
        e = o_st(3'd3, ALU_SW); e.mwr = 1'b1;
        for (int i = 0; i < 14; i++) push("swto_memw", OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e);
        e.berr = 1'b1;
        push("swto_abort", OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e);
        push("swto_after", OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, o_if(1'b0));
        run_sb();

        // Set carry, then reset asynchronously in the middle of a store's MEM state.
        fetch_decode("radd", 0, OP_RTYPE, FN_ADD, 1'b0);
        e = o_st(3'd2, ALU_ADD); e.src_a = 1'b1;
        push("radd_ex", OP_RTYPE, FN_ADD, 1'b0, 1'b1, 1'b0, e);
        exp_carry = 1'b1;
        e = o_st(3'd4, ALU_ADD); e.rw = 1'b1; e.rdst = 1'b1;
        push("radd_wb", OP_RTYPE, FN_ADD, 1'b0, 1'b0, 1'b0, e);
        fetch_decode("rsw", 0, OP_SW, 6'h00, 1'b0);
        e = o_st(3'd2, ALU_SW); e.src_a = 1'b1; e.src_b = 2'b10; e.ext = 1'b1;
        push("rsw_ex", OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, e);
        run_sb();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        e = o_st(3'd3, ALU_SW); e.mwr = 1'b1;
        check("rsw_mem_pre", 32'(obs), 32'(e));
        #1 rst_n = 1'b0;
        exp_carry = 1'b0;
        #1;
        check("rst_in_mem", 32'(obs), 32'(o_if(1'b0)));
        @(posedge clk);
        #2 rst_n = 1'b1;
        fetch_decode("post", 0, OP_BEQ, 6'h00, 1'b0);
        e = o_st(3'd2, ALU_BEQ); e.src_a = 1'b1; e.pcsrc = 1'b1;
        push("post_ex", OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0, e);
        push("post_if", OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0, o_if(1'b0));
        run_sb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the simple CPU datapath. It drives the ALU's 3-bit ALUctrl code and datapath/memory strobes, and consumes the ALU's beq (zero) and carrier flags. It sequences add/sub (R-type), ori, lw, sw and beq through IF/ID/EX/MEM/WB and handles memory wait states with a watchdog.

Parameters:
MEM_TIMEOUT, 15, number of consecutive wait cycles (mem_ready=0) in IF or MEM before abort; must be ≥1.
CW, 4, width of the wait counter; must satisfy 2^CW > MEM_TIMEOUT.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26]; valid from ID onward
funct  in  6  IR[5:0]
zero  in  1  ALU beq flag (result==0)
carrier  in  1  ALU carrier flag (bit 32)
mem_ready  in  1  memory handshake; completes current IF/MEM access
ALUctrl  out  3  001 add, 011 sub, 010 ori, 110 lw, 111 sw, 101 beq
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
ext_op  out  1  1=sign-extend imm, 0=zero-extend
pc_src  out  1  0=ALU result, 1=ALUOut register
pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  strobes
reg_dst  out  1  1=rd, 0=rt
mem_to_reg  out  1  1=MDR, 0=ALUOut
illegal  out  1  one-cycle pulse on undecodable instruction
bus_err  out  1  one-cycle pulse on watchdog abort
carry_flag  out  1  registered carrier of last add/sub
state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4 (debug)

Behaviour:
- Moore outputs decode from state plus the latched instruction class. Unlisted strobes are 0. alu_src_* and ext_op default to 0.
- Reset (async, any state): state=IF, wait counter=0, class=NONE, carry_flag=0. Outputs immediately take IF values: mem_read=1, ALUctrl=001, alu_src_b=01. All other outputs are 0.
- IF: mem_read=1, ALUctrl=001, alu_src_a=0, alu_src_b=01. On a cycle with mem_ready=1: ir_write=1, pc_write=1, next state ID. Otherwise stay in IF and increment the counter.
- ID: ALUctrl=001, alu_src_a=0, alu_src_b=11. Decode op/funct and latch the class: ADD (op 000000, funct 100000), SUB (000000/100010), ORI (001101), LW (100011), SW (101011), BEQ (000100). Any other encoding: illegal=1 and next state IF. Otherwise next state EX.
- EX, by class:
  - ADD: alu_src_a=1, alu_src_b=00, ALUctrl 001.
  - SUB: same sources, ALUctrl 011.
  - ORI: alu_src_a=1, alu_src_b=10, ext_op=0, ALUctrl 010.
  - LW: alu_src_a=1, alu_src_b=10, ext_op=1, ALUctrl 110.
  - SW: same as LW but ALUctrl 111.
  - BEQ: alu_src_a=1, alu_src_b=00, ALUctrl 101, pc_src=1, pc_write=zero.
  - Next state: ADD/SUB/ORI -> WB; LW/SW -> MEM; BEQ -> IF.
  - ADD/SUB only: carry_flag <= carrier at the end of EX. Other classes hold carry_flag.
- MEM: LW holds mem_read=1, SW holds mem_write=1, with address stable from ALUOut. Stay until mem_ready=1, then LW -> WB, SW -> IF.
- WB: reg_write=1 for one cycle. reg_dst=1 for ADD/SUB. mem_to_reg=1 for LW. Next state IF.
- Wait counter:
  - Increments only in IF/MEM while mem_ready=0.
  - Clears on every state change.
  - When it reaches MEM_TIMEOUT-1 with mem_ready still 0: bus_err=1 that cycle, next state IF. No pc_write, ir_write or reg_write occurs.
  - mem_ready=1 on the same cycle as the limit wins (normal completion).
- mem_ready is ignored in ID, EX and WB.
- Instruction latencies with zero wait: BEQ 3 cycles; ADD/SUB/ORI/SW 4; LW 5; illegal 2.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ.
  - funct constants: FN_ADD, FN_SUB.
  - ALUctrl codes: ALU_ADD=001, ALU_SUB=011, ALU_ORI=010, ALU_LW=110, ALU_SW=111, ALU_BEQ=101.
  - state encoding.
  - instruction-class encoding.
- One combinational sub-module, insn_decode (op, funct -> class, illegal). It is shared later with any pipelined controller.

Test Plan:
- rst_n low while in MEM with mem_write=1 -> mem_write drops to 0 immediately (no clock edge), state=0, carry_flag=0. After release, IF outputs are mem_read=1, ALUctrl=001.
- ADD (op 000000, funct 100000), mem_ready=1, carrier=1 in EX -> state sequence 0,1,2,4. ALUctrl=001 each cycle. reg_write=1 with reg_dst=1 in cycle 4. carry_flag=1 after EX.
- LW (100011) with mem_ready low for 3 MEM cycles -> MEM lasts 4 cycles with mem_read=1 and ALUctrl=110 in EX. WB has mem_to_reg=1. 8 cycles total.
- BEQ (000100) with zero=1 -> EX ALUctrl=101, pc_src=1, pc_write=1, back to IF after 3 cycles. Repeat with zero=0 -> pc_write stays 0 in EX.
- op=111111 -> illegal=1 in ID only, next state IF. No reg_write or mem_write. carry_flag unchanged.
- mem_ready held 0 in IF for 15 cycles (MEM_TIMEOUT=15) -> bus_err=1 on the 15th cycle, no ir_write, state restarts IF with counter 0. Repeat with mem_ready=1 on the 15th cycle -> ir_write=1, no bus_err.
